// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter slice.
// Holds the sequencer state encoding, the requester port indices and the
// default number of valid memory words.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  localparam int DEFAULT_DEPTH = 1024;

endpackage : dmem_arb_pkg

// File: rtl/rr_arb2.sv
// Two-way round-robin pick, purely combinational.
// Ports:
//   req_i[1:0] : request vector, bit n = port n
//   last_i     : port that won the previous arbitration
//   valid_o    : at least one request present
//   winner_o   : selected port index (meaningful only when valid_o)
// The history register is owned by the caller.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       valid_o,
  output logic       winner_o
);

  always_comb begin
    valid_o  = |req_i;
    winner_o = P0;
    case (req_i)
      2'b01:   winner_o = P0;
      2'b10:   winner_o = P1;
      // On a tie the port that did not win last time goes next.
      2'b11:   winner_o = ~last_i;
      default: winner_o = P0;
    endcase
  end

endmodule : rr_arb2

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the single-port word-addressed data
// memory (combinational read, write on posedge when WE is high).
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   m0_* (req/we/addr/wdata in,   : port 0, load/store unit
//         gnt/rvalid/rdata out)
//   m1_* (same set)               : port 1, debug/DMA loader
//   mem_we/mem_addr/mem_wdata out : memory control, driven from registers only
//   mem_rdata in                  : memory read data
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | no transaction; arbitrate incoming requests
// ST_ACCESS | memory cycle for the latched request, gnt to owner
// ST_RESP   | rvalid/rdata to owner; arbitrate the next request
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,

  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,

  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  arb_state_e    state_q, state_d;
  logic          rr_last_q, rr_last_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          sel_valid;
  logic          sel_winner;
  logic          in_range;
  logic          in_access;
  logic          in_resp;

  rr_arb2 u_rr_arb2 (
    .req_i    ({m1_req, m0_req}),
    .last_i   (rr_last_q),
    .valid_o  (sel_valid),
    .winner_o (sel_winner)
  );

  assign in_range  = (addr_q < AW'(DEPTH));
  assign in_access = (state_q == ST_ACCESS);
  assign in_resp   = (state_q == ST_RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rr_last_q <= P1;
      owner_q   <= P0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;

    case (state_q)
      // RESP arbitrates like IDLE so back-to-back transfers take 2 cycles.
      ST_IDLE, ST_RESP: begin
        if (sel_valid) begin
          owner_d   = sel_winner;
          rr_last_d = sel_winner;
          we_d      = (sel_winner == P1) ? m1_we    : m0_we;
          addr_d    = (sel_winner == P1) ? m1_addr  : m0_addr;
          wdata_d   = (sel_winner == P1) ? m1_wdata : m0_wdata;
          state_d   = ST_ACCESS;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        // Writes and out-of-range reads report zero data.
        rdata_d = (!we_q && in_range) ? mem_rdata : '0;
        state_d = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Out-of-range writes never reach the memory.
  assign mem_we    = in_access && we_q && in_range;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign m0_gnt    = in_access && (owner_q == P0);
  assign m1_gnt    = in_access && (owner_q == P1);
  assign m0_rvalid = in_resp && (owner_q == P0);
  assign m1_rvalid = in_resp && (owner_q == P1);
  assign m0_rdata  = m0_rvalid ? rdata_q : '0;
  assign m1_rdata  = m1_rvalid ? rdata_q : '0;

endmodule : dmem_arbiter

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port word-addressed Data_Memory: combinational read, write on posedge when WE is high, 1024 words.
- Shares the memory between port 0 (pipeline load/store unit) and port 1 (debug/DMA loader).
- Uses a req/gnt/rvalid handshake and round-robin priority.
- All memory pins are driven from registered state only, never combinationally from requester inputs.

Parameters:
- AW, 32, address width of requester and memory address buses (word address).
- DW, 32, data width.
- DEPTH, 1024, number of valid memory words; addresses >= DEPTH are out of range.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- m0_req  in  1  port 0 request; held high until m0_gnt is seen.
- m0_we  in  1  port 0 write (1) / read (0).
- m0_addr  in  AW  port 0 word address.
- m0_wdata  in  DW  port 0 write data.
- m0_gnt  out  1  port 0 request accepted (1-cycle pulse).
- m0_rvalid  out  1  port 0 response valid (1-cycle pulse; read data or write ack).
- m0_rdata  out  DW  port 0 read data, valid while m0_rvalid.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as the port 0 signals, for port 1.
- mem_we  out  1  to memory WE.
- mem_addr  out  AW  to memory A.
- mem_wdata  out  DW  to memory WD.
- mem_rdata  in  DW  from memory RD (combinational on mem_addr).

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset (async, takes effect immediately; also mid-transaction):
  - state=IDLE, rr_last=1 (port 0 wins the first tie).
  - Latched owner/addr/we/wdata cleared.
  - All outputs 0. mem_we=0 regardless of clock.
  - Any in-flight transaction is dropped with no gnt/rvalid.
- Selection, evaluated in IDLE and RESP:
  - Only m0_req high: pick port 0. Only m1_req high: pick port 1.
  - Both high: pick the port != rr_last.
  - On selection, latch owner, addr, we and wdata at the posedge, set rr_last=owner, go to ACCESS.
  - No request: go to IDLE.
- ACCESS (exactly 1 cycle):
  - mem_addr=latched addr, mem_wdata=latched wdata.
  - mem_we=latched we AND addr<DEPTH. An out-of-range write is suppressed.
  - gnt[owner]=1 for this cycle only. The requester may change or drop req from the next cycle.
  - At posedge, capture rdata: mem_rdata if read and in range, else 0.
  - Go to RESP.
- RESP (exactly 1 cycle):
  - rvalid[owner]=1, rdata[owner]=captured value. Writes also get rvalid with rdata=0.
  - mem_we=0. mem_addr holds the latched address.
  - The same-cycle selection runs here, so back-to-back transactions complete every 2 cycles.
- The non-owner port's gnt, rvalid and rdata are 0 at all times.
- Latency:
  - Request seen in IDLE at cycle N: gnt in N+1, rvalid in N+2.
  - A request losing a tie waits one transaction (2 cycles) more.
- Fairness: with both ports requesting continuously, grants strictly alternate 0,1,0,1… No starvation.
- Read-after-write: a write in transaction k is visible to a read in transaction k+1, because the memory write commits at the end of ACCESS.
- Idle outputs: mem_we=0 in IDLE and RESP. mem_addr/mem_wdata hold their last latched values; they are don't-care and must not toggle spuriously.

Decomposition:
- Package dmem_arb_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_RESP=2'd2.
  - Port index constants P0=1'b0, P1=1'b1.
  - Default DEPTH.
- Sub-module rr_arb2: a pure combinational 2-way round-robin pick.
  - Inputs: req[1:0], last.
  - Outputs: valid, winner.
  - The rr_last register stays in dmem_arbiter.

Test Plan:
1. Single read: after reset, m0_req=1, m0_we=0, m0_addr=28; memory preloaded mem[28]=0x00000020 -> m0_gnt at cycle 1, m0_rvalid with m0_rdata=0x00000020 at cycle 2; m1 outputs 0 throughout.
2. Write then read: m1 writes 0xDEADBEEF to addr 40, then reads addr 40 -> mem_we high exactly 1 cycle with mem_addr=40; the read returns 0xDEADBEEF; the write's rvalid has rdata=0.
3. Tie/round-robin: both ports hold req continuously from cycle 0 with reads of addrs 1 and 2 -> grants ordered 0,1,0,1, gnt pulses 2 cycles apart; each rdata goes only to its owner.
4. Out of range: m0 writes 0x12345678 to addr 1024, then reads 1024 -> mem_we stays 0; rvalid asserted for both; read rdata=0.
5. Reset mid-operation: assert rst asynchronously during ACCESS of a write -> mem_we drops immediately; no rvalid; state IDLE; port 0 wins the next tie.
6. Back-to-back same port: m0 issues 4 reads (addrs 3,4,5,6) with req kept high -> 4 gnt and 4 rvalid pulses at a 2-cycle cadence, data in order.
